fade_apply: RTL and testbench

- Sits directly downstream of fader and consumes its per-channel complex fading coefficients (dv_out/chan_out/Zc_real/Zc_imag).
- Captures each coefficient burst into a double-buffered coefficient bank.
- Swaps banks atomically once a full set of NCHAN coefficients has arrived.
- Multiplies a channel-tagged complex sample stream by the active coefficient of its channel, with rounding and saturation.

---
 rtl/fade_pkg.sv | 38 +++
 rtl/fade_apply_cmult_rnd_sat.sv | 85 ++++++++
 rtl/fade_apply.sv | 131 +++++++++++++
 tb/tb_fade_apply.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fade_pkg.sv
// Shared widths, complex payload types and the round/saturate helper for fade_apply.
package fade_pkg;

  localparam int unsigned NCHAN = 32;
  localparam int unsigned CHW   = 5;
  localparam int unsigned CW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned FRAC  = 15;
  localparam int unsigned MW    = DW + CW;
  localparam int unsigned PW    = DW + CW + 1;

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } cplx_coef_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_samp_t;

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] RND     = PW'(2 ** (FRAC - 1));

  // Returns {clipped, value}: round-half-up, arithmetic shift, clamp to DW bits.
  function automatic logic [DW:0] round_sat(input logic signed [PW-1:0] acc);
    logic signed [PW-1:0] sh;
    sh = (acc + RND) >>> FRAC;
    if (sh > PW'(SAT_MAX)) begin
      return {1'b1, SAT_MAX};
    end else if (sh < PW'(SAT_MIN)) begin
      return {1'b1, SAT_MIN};
    end
    return {1'b0, sh[DW-1:0]};
  endfunction

endpackage

// File: rtl/fade_apply_cmult_rnd_sat.sv
// Two-stage complex multiply (products, then sum/round/saturate) with valid/channel sideband.
module cmult_rnd_sat
  import fade_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_chan,
  input  cplx_samp_t     in_samp,
  input  cplx_coef_t     in_coef,
  output logic           out_valid,
  output logic [CHW-1:0] out_chan,
  output cplx_samp_t     out_samp,
  output logic           out_sat
);

  logic                 p_valid_q, p_valid_d;
  logic [CHW-1:0]       p_chan_q, p_chan_d;
  logic signed [MW-1:0] p_ac_q, p_ac_d, p_bd_q, p_bd_d;
  logic signed [MW-1:0] p_ad_q, p_ad_d, p_bc_q, p_bc_d;

  logic                 out_valid_q, out_valid_d;
  logic [CHW-1:0]       out_chan_q, out_chan_d;
  cplx_samp_t           out_samp_q, out_samp_d;
  logic                 out_sat_q, out_sat_d;

  logic signed [PW-1:0] re_acc_c, im_acc_c;
  logic [DW:0]          re_rs_c, im_rs_c;

  always_comb begin
    p_valid_d = in_valid;
    p_chan_d  = in_chan;
    p_ac_d    = MW'(in_samp.re) * MW'(in_coef.re);
    p_bd_d    = MW'(in_samp.im) * MW'(in_coef.im);
    p_ad_d    = MW'(in_samp.re) * MW'(in_coef.im);
    p_bc_d    = MW'(in_samp.im) * MW'(in_coef.re);

    re_acc_c  = PW'(p_ac_q) - PW'(p_bd_q);
    im_acc_c  = PW'(p_ad_q) + PW'(p_bc_q);
    re_rs_c   = round_sat(re_acc_c);
    im_rs_c   = round_sat(im_acc_c);

    out_valid_d = p_valid_q;
    out_chan_d  = p_chan_q;
    out_samp_d  = '0;
    out_sat_d   = 1'b0;
    if (p_valid_q) begin
      out_samp_d.re = re_rs_c[DW-1:0];
      out_samp_d.im = im_rs_c[DW-1:0];
      out_sat_d     = re_rs_c[DW] | im_rs_c[DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid_q   <= 1'b0;
      p_chan_q    <= '0;
      p_ac_q      <= '0;
      p_bd_q      <= '0;
      p_ad_q      <= '0;
      p_bc_q      <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_samp_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_chan_q    <= p_chan_d;
      p_ac_q      <= p_ac_d;
      p_bd_q      <= p_bd_d;
      p_ad_q      <= p_ad_d;
      p_bc_q      <= p_bc_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_samp_q  <= out_samp_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_samp  = out_samp_q;
  assign out_sat   = out_sat_q;

endmodule

// File: rtl/fade_apply.sv
// Double-buffered per-channel fading coefficients applied to a channel-tagged sample stream.
// Optional saturation counter port sat_count is built when FADE_APPLY_SATCNT_EN is defined.
module fade_apply
  import fade_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           coef_dv,
  input  logic [CHW-1:0] coef_chan,
  input  logic [CW-1:0]  coef_real,
  input  logic [CW-1:0]  coef_imag,
  input  logic           s_valid,
  input  logic [CHW-1:0] s_chan,
  input  logic [DW-1:0]  s_real,
  input  logic [DW-1:0]  s_imag,
  output logic           m_valid,
  output logic [CHW-1:0] m_chan,
  output logic [DW-1:0]  m_real,
  output logic [DW-1:0]  m_imag,
  output logic           m_sat,
  output logic           coef_ready,
  output logic           swap_pulse
`ifdef FADE_APPLY_SATCNT_EN
  ,
  output logic [15:0]    sat_count
`endif
);

  cplx_coef_t       bank_q [2][NCHAN];
  logic [NCHAN-1:0] mask_q, mask_d;
  logic             act_q, act_d;
  logic             swap_pulse_q, swap_pulse_d;
  logic             coef_ready_q, coef_ready_d;

  logic             s1_valid_q, s1_valid_d;
  logic [CHW-1:0]   s1_chan_q, s1_chan_d;
  cplx_samp_t       s1_samp_q, s1_samp_d;
  cplx_coef_t       s1_coef_q, s1_coef_d;

  logic             wr_en_c, wr_bank_c, s_in_range_c;
  cplx_samp_t       m_samp;

  // Swap fires the cycle after the mask fills; a write in that cycle lands in the new shadow.
  always_comb begin
    wr_en_c      = coef_dv && (32'(coef_chan) < NCHAN);
    wr_bank_c    = swap_pulse_q ? act_q : ~act_q;
    mask_d       = swap_pulse_q ? '0 : mask_q;
    if (wr_en_c) begin
      mask_d = mask_d | (NCHAN'(1) << coef_chan);
    end
    swap_pulse_d = &mask_d;
    act_d        = act_q ^ swap_pulse_q;
    coef_ready_d = coef_ready_q | swap_pulse_q;

    s_in_range_c = 32'(s_chan) < NCHAN;
    s1_valid_d   = s_valid && coef_ready_q;
    s1_chan_d    = s_chan;
    s1_samp_d.re = s_real;
    s1_samp_d.im = s_imag;
    s1_coef_d    = s_in_range_c ? bank_q[act_q][s_chan] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q       <= '0;
      act_q        <= 1'b0;
      swap_pulse_q <= 1'b0;
      coef_ready_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_chan_q    <= '0;
      s1_samp_q    <= '0;
      s1_coef_q    <= '0;
    end else begin
      mask_q       <= mask_d;
      act_q        <= act_d;
      swap_pulse_q <= swap_pulse_d;
      coef_ready_q <= coef_ready_d;
      s1_valid_q   <= s1_valid_d;
      s1_chan_q    <= s1_chan_d;
      s1_samp_q    <= s1_samp_d;
      s1_coef_q    <= s1_coef_d;
    end
  end

  // Bank storage has no reset; validity is tracked solely by the mask and coef_ready.
  always_ff @(posedge clk) begin
    if (wr_en_c && !reset) begin
      bank_q[wr_bank_c][coef_chan] <= {coef_real, coef_imag};
    end
  end

  cmult_rnd_sat u_cmult (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid_q),
    .in_chan   (s1_chan_q),
    .in_samp   (s1_samp_q),
    .in_coef   (s1_coef_q),
    .out_valid (m_valid),
    .out_chan  (m_chan),
    .out_samp  (m_samp),
    .out_sat   (m_sat)
  );

  assign m_real     = m_samp.re;
  assign m_imag     = m_samp.im;
  assign coef_ready = coef_ready_q;
  assign swap_pulse = swap_pulse_q;

`ifdef FADE_APPLY_SATCNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    if (m_valid && m_sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_fade_apply.sv
// Directed self-checking bench for fade_apply: drop before ready, swap timing, math, saturation, reset.
module tb_fade_apply;
  import fade_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 coef_dv;
  logic [CHW-1:0]       coef_chan;
  logic signed [CW-1:0] coef_real, coef_imag;
  logic                 s_valid;
  logic [CHW-1:0]       s_chan;
  logic signed [DW-1:0] s_real, s_imag;
  logic                 m_valid;
  logic [CHW-1:0]       m_chan;
  logic signed [DW-1:0] m_real, m_imag;
  logic                 m_sat;
  logic                 coef_ready;
  logic                 swap_pulse;
`ifdef FADE_APPLY_SATCNT_EN
  logic [15:0]          sat_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int q_re[$];
  int q_im[$];

  always #5 clk = ~clk;

  fade_apply dut (
    .clk        (clk),
    .reset      (reset),
    .coef_dv    (coef_dv),
    .coef_chan  (coef_chan),
    .coef_real  (coef_real),
    .coef_imag  (coef_imag),
    .s_valid    (s_valid),
    .s_chan     (s_chan),
    .s_real     (s_real),
    .s_imag     (s_imag),
    .m_valid    (m_valid),
    .m_chan     (m_chan),
    .m_real     (m_real),
    .m_imag     (m_imag),
    .m_sat      (m_sat),
    .coef_ready (coef_ready),
    .swap_pulse (swap_pulse)
`ifdef FADE_APPLY_SATCNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int ch, input int re, input int im);
    coef_dv   = 1'b1;
    coef_chan = CHW'(ch);
    coef_real = CW'(re);
    coef_imag = CW'(im);
    tick();
    coef_dv   = 1'b0;
  endtask

  task automatic send_and_check(input string tag, input int ch, input int re, input int im,
                                input int exp_re, input int exp_im, input int exp_sat);
    s_valid = 1'b1;
    s_chan  = CHW'(ch);
    s_real  = DW'(re);
    s_imag  = DW'(im);
    tick();
    s_valid = 1'b0;
    tick();
    check({tag, "_early"}, m_valid, 0);
    tick();
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_chan"}, m_chan, ch);
    check({tag, "_re"}, m_real, exp_re);
    check({tag, "_im"}, m_imag, exp_im);
    check({tag, "_sat"}, m_sat, exp_sat);
  endtask

  initial begin
    reset = 1'b1; coef_dv = 1'b0; coef_chan = '0; coef_real = '0; coef_imag = '0;
    s_valid = 1'b0; s_chan = '0; s_real = '0; s_imag = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_m_valid", m_valid, 0);
    check("rst_coef_ready", coef_ready, 0);
    check("rst_swap", swap_pulse, 0);
    check("rst_m_real", m_real, 0);

    // Samples before any coefficient set must be dropped
    s_valid = 1'b1; s_chan = 5'd3; s_real = 16'sd100; s_imag = 16'sd100;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("prefill_valid", m_valid, 0);
    end
    s_valid = 1'b0;
    tick(); tick(); tick();
    check("prefill_tail", m_valid, 0);
    check("prefill_ready", coef_ready, 0);

    // First set: unit gain except chan 5 = j/2, chan 9 = -1
    for (int ch = 0; ch < 32; ch++) begin
      write_coef(ch, (ch == 5) ? 0 : (ch == 9) ? -32768 : 32767, (ch == 5) ? 16384 : 0);
      if (ch < 31) check("fill_no_swap", swap_pulse, 0);
    end
    check("fill_swap", swap_pulse, 1);
    check("fill_ready_pre", coef_ready, 0);
    s_valid = 1'b1; s_chan = 5'd3; s_real = 16'sd1000; s_imag = -16'sd2000;
    tick();
    check("swap_one_cycle", swap_pulse, 0);
    check("fill_ready", coef_ready, 1);
    tick();
    s_valid = 1'b0;
    tick();
    check("swapcycle_drop", m_valid, 0);
    tick();
    check("unit_valid", m_valid, 1);
    check("unit_chan", m_chan, 3);
    check("unit_re", m_real, 1000);
    check("unit_im", m_imag, -2000);
    check("unit_sat", m_sat, 0);

    send_and_check("cmul", 5, 4000, 6000, -3000, 2000, 0);
    send_and_check("satur", 9, -32768, 0, 32767, 0, 1);
`ifdef FADE_APPLY_SATCNT_EN
    tick();
    check("sat_count", sat_count, 1);
`endif

    // Stream chan 7 while a second set arrives in reverse order; chan 0 lands at k=31
    for (int k = 0; k < 40; k++) begin
      s_valid = 1'b1; s_chan = 5'd7; s_real = 16'sd1000; s_imag = 16'sd0;
      if (k < 32) begin
        coef_dv   = 1'b1;
        coef_chan = CHW'(31 - k);
        coef_real = (31 - k == 7) ? 16'sd0 : 16'sd32767;
        coef_imag = (31 - k == 7) ? 16'sd32767 : 16'sd0;
      end else begin
        coef_dv = 1'b0;
      end
      check("stream_swap_at", swap_pulse, (k == 32));
      q_re.push_back((k > 32) ? 0 : 1000);
      q_im.push_back((k > 32) ? 1000 : 0);
      tick();
      if (k >= 2) check("stream_valid", m_valid, 1);
      if (m_valid && q_re.size() > 0) begin
        check("stream_re", m_real, q_re.pop_front());
        check("stream_im", m_imag, q_im.pop_front());
      end
    end
    s_valid = 1'b0; coef_dv = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("drain_valid", m_valid, 1);
      if (m_valid && q_re.size() > 0) begin
        check("drain_re", m_real, q_re.pop_front());
        check("drain_im", m_imag, q_im.pop_front());
      end
    end
    check("stream_left", q_re.size(), 0);

    // Partial burst, reset, then a set needing all 32 channels again
    for (int ch = 0; ch <= 20; ch++) write_coef(ch, 12345, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", coef_ready, 0);
    check("mid_rst_swap", swap_pulse, 0);
    check("mid_rst_valid", m_valid, 0);
`ifdef FADE_APPLY_SATCNT_EN
    check("mid_rst_satcnt", sat_count, 0);
`endif
    for (int ch = 21; ch < 32; ch++) begin
      write_coef(ch, 32767, 0);
      check("partial_no_swap", swap_pulse, 0);
    end
    s_valid = 1'b1; s_chan = 5'd7; s_real = 16'sd1000; s_imag = 16'sd0;
    tick();
    s_valid = 1'b0;
    check("partial_no_swap2", swap_pulse, 0);
    tick(); tick();
    check("partial_drop", m_valid, 0);
    for (int ch = 0; ch <= 20; ch++) begin
      write_coef(ch, (ch == 7) ? 16384 : 32767, 0);
      check("refill_swap", swap_pulse, (ch == 20));
    end
    tick();
    check("refill_ready", coef_ready, 1);
    send_and_check("refill_c7", 7, 1000, 0, 500, 0, 0);
    send_and_check("refill_c21", 21, 2000, -4000, 2000, -4000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
